// File: rtl/alarme_pkg.sv
// alarme_pkg: shared definitions for the alarm controller.
//   - state encoding (IDLE..SIREN) and its 3-bit width
//   - trigger-event counter width and its saturation value
//   - small helper for the saturating event increment
package alarme_pkg;

    localparam int unsigned ST_W = 3;

    // Codes 5..7 are unused; the FSM treats them as illegal and returns to IDLE.
    typedef enum logic [ST_W-1:0] {
        IDLE  = 3'd0,
        EXIT  = 3'd1,
        ARMD  = 3'd2,
        ENTRY = 3'd3,
        SIREN = 3'd4
    } state_e;

    localparam int unsigned    EVT_W   = 4;
    localparam logic [EVT_W-1:0] EVT_MAX = 4'd15;

    // Increment that holds at EVT_MAX instead of wrapping.
    function automatic logic [EVT_W-1:0] evt_sat_inc(input logic [EVT_W-1:0] cur);
        if (cur == EVT_MAX) begin
            return cur;
        end
        return cur + EVT_W'(1);
    endfunction

endpackage

// File: rtl/cont_regressivo.sv
// cont_regressivo: CW-bit loadable down-counter used for the exit, entry and
// siren delays.
// Ports:
//   clk   in   clock, rising edge
//   rst   in   synchronous active-high reset (counter -> 0)
//   load  in   load counter with val
//   clr   in   clear counter to 0 (wins over load)
//   val   in   CW-bit load value
//   zero  out  counter is 0
// The counter decrements every cycle while non-zero and holds at 0.
module cont_regressivo #(
    parameter int unsigned CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clr,
    input  logic [CW-1:0] val,
    output logic          zero
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (load) begin
            cnt_d = val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/alarme_ctrl.sv
// alarme_ctrl: sequential alarm controller downstream of the sensor logic.
// Adds arming/disarming, an exit delay, an entry delay, a timed siren with
// retrigger and a saturating count of siren triggers.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   A      in   alarm condition from the sensor-logic stage
//   ARM    in   arm request (honoured only in IDLE)
//   DIS    in   disarm request (honoured in every state, highest priority)
//   SIR    out  siren drive
//   ARMED  out  armed indicator
//   PEND   out  entry-delay warning
//   ST     out  current state code
//   EVT    out  siren trigger count, saturating at 15
// Moore machine: every output is decoded from registered state only.
module alarme_ctrl
    import alarme_pkg::*;
#(
    parameter int unsigned EXIT_DLY   = 8,
    parameter int unsigned ENTRY_DLY  = 4,
    parameter int unsigned SIREN_TIME = 16,
    parameter int unsigned CW         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A,
    input  logic             ARM,
    input  logic             DIS,
    output logic             SIR,
    output logic             ARMED,
    output logic             PEND,
    output logic [ST_W-1:0]  ST,
    output logic [EVT_W-1:0] EVT
);

    // Loads are duration-1 because the state is entered on the load edge and
    // left on the edge that sees the counter at 0.
    localparam logic [CW-1:0] EXIT_LD  = CW'(EXIT_DLY - 1);
    localparam logic [CW-1:0] ENTRY_LD = CW'(ENTRY_DLY - 1);
    localparam logic [CW-1:0] SIREN_LD = CW'(SIREN_TIME - 1);

    state_e           state_q;
    state_e           state_d;
    logic [EVT_W-1:0] evt_q;
    logic [EVT_W-1:0] evt_d;

    logic             cnt_load;
    logic             cnt_clr;
    logic [CW-1:0]    cnt_val;
    logic             cnt_zero;
    logic             evt_inc;

    cont_regressivo #(
        .CW(CW)
    ) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .load (cnt_load),
        .clr  (cnt_clr),
        .val  (cnt_val),
        .zero (cnt_zero)
    );

    // Next-state logic. DIS overrides everything, including a counter expiry
    // on the same edge, so no event is counted in that case.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_clr  = 1'b0;
        cnt_val  = '0;
        evt_inc  = 1'b0;

        if (DIS) begin
            state_d = IDLE;
            cnt_clr = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ARM) begin
                        state_d  = EXIT;
                        cnt_load = 1'b1;
                        cnt_val  = EXIT_LD;
                    end
                end
                EXIT: begin
                    // A is deliberately ignored while the occupant leaves.
                    if (cnt_zero) begin
                        state_d = ARMD;
                    end
                end
                ARMD: begin
                    if (A) begin
                        state_d  = ENTRY;
                        cnt_load = 1'b1;
                        cnt_val  = ENTRY_LD;
                    end
                end
                ENTRY: begin
                    // Dropping A here does not cancel the entry delay.
                    if (cnt_zero) begin
                        state_d  = SIREN;
                        cnt_load = 1'b1;
                        cnt_val  = SIREN_LD;
                        evt_inc  = 1'b1;
                    end
                end
                SIREN: begin
                    if (cnt_zero) begin
                        if (A) begin
                            cnt_load = 1'b1;
                            cnt_val  = SIREN_LD;
                            evt_inc  = 1'b1;
                        end else begin
                            state_d = ARMD;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        evt_d = evt_q;
        if (evt_inc) begin
            evt_d = evt_sat_inc(evt_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            evt_q   <= evt_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        SIR   = 1'b0;
        ARMED = 1'b0;
        PEND  = 1'b0;
        case (state_q)
            ARMD: begin
                ARMED = 1'b1;
            end
            ENTRY: begin
                ARMED = 1'b1;
                PEND  = 1'b1;
            end
            SIREN: begin
                ARMED = 1'b1;
                SIR   = 1'b1;
            end
            default: begin
                SIR   = 1'b0;
            end
        endcase
    end

    assign ST  = state_q;
    assign EVT = evt_q;

endmodule

// File: tb/tb_alarme_ctrl.sv
// tb_alarme_ctrl: directed bench for alarme_ctrl with a phase/elapsed-time
// reference model and literal checkpoints at the interesting edges.
module tb_alarme_ctrl;
    import alarme_pkg::*;

    localparam int EXIT_DLY   = 8;
    localparam int ENTRY_DLY  = 4;
    localparam int SIREN_TIME = 16;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       A     = 1'b0;
    logic       ARM   = 1'b0;
    logic       DIS   = 1'b0;
    logic       SIR;
    logic       ARMED;
    logic       PEND;
    logic [2:0] ST;
    logic [3:0] EVT;

    int errors = 0;
    int checks = 0;
    int sir_cnt;
    int pend_cnt;

    alarme_ctrl #(
        .EXIT_DLY   (EXIT_DLY),
        .ENTRY_DLY  (ENTRY_DLY),
        .SIREN_TIME (SIREN_TIME),
        .CW         (8)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .A     (A),
        .ARM   (ARM),
        .DIS   (DIS),
        .SIR   (SIR),
        .ARMED (ARMED),
        .PEND  (PEND),
        .ST    (ST),
        .EVT   (EVT)
    );

    always #5 clk = ~clk;

    // Reference model: phase number plus cycles already spent in that phase.
    int m_ph  = 0;
    int m_el  = 0;
    int m_evt = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph  <= 0;
            m_el  <= 0;
            m_evt <= 0;
        end else if (DIS) begin
            m_ph <= 0;
            m_el <= 0;
        end else begin
            case (m_ph)
                0: if (ARM) begin m_ph <= 1; m_el <= 0; end
                1: begin
                    if (m_el + 1 == EXIT_DLY) begin m_ph <= 2; m_el <= 0; end
                    else m_el <= m_el + 1;
                end
                2: if (A) begin m_ph <= 3; m_el <= 0; end
                3: begin
                    if (m_el + 1 == ENTRY_DLY) begin
                        m_ph  <= 4;
                        m_el  <= 0;
                        m_evt <= (m_evt < 15) ? m_evt + 1 : 15;
                    end else m_el <= m_el + 1;
                end
                4: begin
                    if (m_el + 1 == SIREN_TIME) begin
                        m_el <= 0;
                        if (A) m_evt <= (m_evt < 15) ? m_evt + 1 : 15;
                        else   m_ph  <= 2;
                    end else m_el <= m_el + 1;
                end
                default: begin m_ph <= 0; m_el <= 0; end
            endcase
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock edge with the given inputs, then compare every output to the model.
    task automatic step(input logic a, input logic arm, input logic dis, input logic r);
        A   = a;
        ARM = arm;
        DIS = dis;
        rst = r;
        @(posedge clk);
        #1;
        chk("model_ST",    int'(ST),    m_ph);
        chk("model_SIR",   int'(SIR),   int'(m_ph == 4));
        chk("model_ARMED", int'(ARMED), int'(m_ph >= 2 && m_ph <= 4));
        chk("model_PEND",  int'(PEND),  int'(m_ph == 3));
        chk("model_EVT",   int'(EVT),   m_evt);
    endtask

    task automatic arm_to_armd();
        step(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (EXIT_DLY) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // From ARMD: A edge into ENTRY, then ENTRY_DLY edges to reach SIREN.
    task automatic trigger_to_siren();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (ENTRY_DLY) step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset with A high, then idle.
        step(1'b1, 1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_ST", int'(ST), 0);
        chk("rst_EVT", int'(EVT), 0);
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("idle_ST", int'(ST), 0);
        chk("idle_SIR", int'(SIR), 0);
        chk("idle_ARMED", int'(ARMED), 0);

        // Arm and trigger with default delays.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        chk("arm_ST_t", int'(ST), 1);
        repeat (7) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("arm_ST_t7", int'(ST), 1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("arm_ST_t8", int'(ST), 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        pend_cnt = int'(PEND);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            pend_cnt += int'(PEND);
        end
        chk("entry_pend_cycles", pend_cnt, 4);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("siren_SIR", int'(SIR), 1);
        chk("siren_EVT", int'(EVT), 1);
        sir_cnt = int'(SIR);
        repeat (15) begin
            step(1'b0, 1'b0, 1'b0, 1'b0);
            sir_cnt += int'(SIR);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("siren_len", sir_cnt, 16);
        chk("siren_end_ST", int'(ST), 2);

        // Disarm in the second ENTRY cycle.
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dis_entry_ST", int'(ST), 0);
        repeat (6) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("dis_entry_EVT", int'(EVT), 1);

        // DIS on the same edge as the entry expiry: IDLE, no event.
        arm_to_armd();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (ENTRY_DLY - 1) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("dis_expiry_ST", int'(ST), 0);
        chk("dis_expiry_EVT", int'(EVT), 1);

        // Retrigger: three siren periods from a fresh reset.
        step(1'b0, 1'b0, 1'b0, 1'b1);
        arm_to_armd();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (ENTRY_DLY) step(1'b1, 1'b0, 1'b0, 1'b0);
        sir_cnt = int'(SIR);
        repeat (47) begin
            step(1'b1, 1'b0, 1'b0, 1'b0);
            sir_cnt += int'(SIR);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("retrig_len", sir_cnt, 48);
        chk("retrig_ST", int'(ST), 2);
        chk("retrig_EVT", int'(EVT), 3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("retrig_dis_ST", int'(ST), 0);
        chk("retrig_dis_ARMED", int'(ARMED), 0);
        chk("retrig_dis_EVT", int'(EVT), 3);

        // Reset mid-SIREN.
        arm_to_armd();
        trigger_to_siren();
        repeat (5) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        chk("rst_siren_SIR", int'(SIR), 0);
        chk("rst_siren_ARMED", int'(ARMED), 0);
        chk("rst_siren_ST", int'(ST), 0);
        chk("rst_siren_EVT", int'(EVT), 0);

        // Saturation: 17 triggers (entry + 16 retriggers).
        arm_to_armd();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (ENTRY_DLY) step(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (16 * SIREN_TIME) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("sat_EVT", int'(EVT), 15);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_dis_EVT", int'(EVT), 15);

        // ARM and DIS together in IDLE.
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("armdis_ST", int'(ST), 0);

        // A toggling during EXIT has no effect.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < EXIT_DLY; i++) begin
            step(i[0], 1'b0, 1'b0, 1'b0);
        end
        chk("exit_toggle_ST", int'(ST), 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);

        // Forced illegal state recovers to IDLE on the next edge.
        force dut.state_q = state_e'(3'd6);
        #1;
        chk("illegal_visible_ST", int'(ST), 6);
        release dut.state_q;
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("illegal_recover_ST", int'(ST), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
